// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the PC register / instruction
// memory and decode. Each entry holds one fetched packet {pc, incPC, instr}.
// A small circular FIFO decouples fetch from decode stalls; a flush discards
// every buffered packet in one cycle.
//
// Ports:
//   clk                clock, all state updates on posedge
//   triggerRstN        synchronous active-low reset
//   inValid/inReady    fetch-side handshake; a packet is pushed when both are 1
//   inPC/inIncPC       pc and pc+4 of the fetched instruction
//   inInstr            instruction word
//   outValid/outReady  decode-side handshake; the head is popped when both are 1
//   outPC/outIncPC     head entry pc / incPC
//   outInstr           head entry instruction
//   flush              redirect: empty the queue
//   count              current occupancy (0..DEPTH)
//   almostFull         count >= DEPTH-1, early stall hint for the PC register
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     triggerRstN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [ADDR_WIDTH-1:0]    inPC,
    input  logic [ADDR_WIDTH-1:0]    inIncPC,
    input  logic [DATA_WIDTH-1:0]    inInstr,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [ADDR_WIDTH-1:0]    outPC,
    output logic [ADDR_WIDTH-1:0]    outIncPC,
    output logic [DATA_WIDTH-1:0]    outInstr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almostFull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [ADDR_WIDTH-1:0] pcMem    [DEPTH];
    logic [ADDR_WIDTH-1:0] incPcMem [DEPTH];
    logic [DATA_WIDTH-1:0] instrMem [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Handshake flags come only from registered occupancy, so there is no
    // combinational path from outReady to inReady.
    assign inReady    = (cnt != FULL_CNT);
    assign outValid   = (cnt != '0);
    assign almostFull = (cnt >= AFULL_CNT);
    assign count      = cnt;

    assign push = inValid && inReady;
    assign pop  = outValid && outReady;

    // No bypass: the head always comes from storage, so a pushed packet is
    // visible one cycle after it is written at the earliest.
    assign outPC    = pcMem[rdPtr];
    assign outIncPC = incPcMem[rdPtr];
    assign outInstr = instrMem[rdPtr];

    always_ff @(posedge clk) begin
        if (!triggerRstN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem[i]    <= '0;
                incPcMem[i] <= '0;
                instrMem[i] <= '0;
            end
        end else if (flush) begin
            // Concurrent push/pop are dropped; entry contents are left as is.
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                pcMem[wrPtr]    <= inPC;
                incPcMem[wrPtr] <= inIncPC;
                instrMem[wrPtr] <= inInstr;
                wrPtr           <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
